// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and read-sequencer state type for the FIFO access controller.
// No logic and no latency; widths and limits only.
package fifo_ctrl_pkg;

  localparam int FIFO_WIDTH = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int N_REQ_MIN  = 2;
  localparam int N_REQ_MAX  = 4;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_HOLD  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rate_strobe.sv
// Free-running slot generator: strobe is high one cycle in every DIV, in the last count.
// Never stalls; strobe is forced low while rst is high.
module rate_strobe #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic strobe
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign strobe = !rst && (r_cnt == LAST);

endmodule

// File: rtl/fifo_access_ctrl.sv
// Round-robin producer arbiter onto the FIFO write port plus a one-outstanding read sequencer.
// Write grant is same-cycle within a slot (lost on full); out_valid follows rd_en by 2 edges, held until out_ready.
module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int N_REQ  = 2,
  parameter int WR_DIV = 2,
  parameter int RD_DIV = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  input  logic                     fifo_full,
  output logic                     fifo_rd_en,
  input  logic [WIDTH-1:0]         fifo_rdata,
  input  logic                     fifo_empty,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(N_REQ);

  logic            w_wr_slot;
  logic            w_rd_slot;
  logic            w_wr_go;
  logic [GW-1:0]   w_grant;
  logic [GW-1:0]   w_cand;
  logic [GW-1:0]   r_rr;
  logic [GW-1:0]   r_grant_id;
  rd_state_t       r_rd_state;
  logic            r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  rate_strobe #(.DIV(WR_DIV)) u_wr_strobe (
    .clk    (clk),
    .rst    (rst),
    .strobe (w_wr_slot)
  );

  rate_strobe #(.DIV(RD_DIV)) u_rd_strobe (
    .clk    (clk),
    .rst    (rst),
    .strobe (w_rd_slot)
  );

  // Walk candidates from farthest to nearest so the nearest valid one after r_rd wins.
  always_comb begin
    w_grant = r_rr;
    w_cand  = r_rr;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = GW'((int'(r_rr) + k) % N_REQ);
      if (req_valid[w_cand]) begin
        w_grant = w_cand;
      end
    end
  end

  assign w_wr_go = w_wr_slot && !fifo_full && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (w_wr_go) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  assign fifo_wr_en = w_wr_go;
  assign fifo_wdata = w_wr_go ? req_data[w_grant*WIDTH +: WIDTH] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr       <= GW'(N_REQ - 1);
      r_grant_id <= '0;
    end else if (w_wr_go) begin
      r_rr       <= w_grant;
      r_grant_id <= w_grant;
    end
  end

  assign grant_id = r_grant_id;

  assign fifo_rd_en = (r_rd_state == RD_IDLE) && w_rd_slot && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state  <= RD_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (fifo_rd_en) begin
            r_rd_state <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          r_out_data  <= fifo_rdata;
          r_out_valid <= 1'b1;
          r_rd_state  <= RD_HOLD;
        end
        RD_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_rd_state  <= RD_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_rd_state  <= RD_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Randomized and directed bench for fifo_access_ctrl against a slot/latency reference model and a queue-backed FIFO.
module tb_fifo_access_ctrl;

  localparam int WIDTH  = 4;
  localparam int N_REQ  = 2;
  localparam int WR_DIV = 2;
  localparam int RD_DIV = 3;
  localparam int DEPTH  = 8;
  localparam int GW     = $clog2(N_REQ);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_wr_en;
  logic [WIDTH-1:0]       fifo_wdata;
  logic                   fifo_full;
  logic                   fifo_rd_en;
  logic [WIDTH-1:0]       fifo_rdata;
  logic                   fifo_empty;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic [GW-1:0]          grant_id;

  always #5 clk = ~clk;

  fifo_access_ctrl #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ),
    .WR_DIV(WR_DIV),
    .RD_DIV(RD_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .grant_id   (grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles since reset release, last granted producer, read pipeline.
  int t;
  int last_g;
  int m_gid;
  int pend;
  int pend_val;
  int m_ov;
  int m_od;
  bit rdata_next;
  bit force_full;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    t          = 0;
    last_g     = N_REQ - 1;
    m_gid      = 0;
    pend       = 0;
    m_ov       = 0;
    m_od       = 0;
    rdata_next = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_wr_en"},     32'(fifo_wr_en), 32'd0);
    chk({tag, "_wdata"},     32'(fifo_wdata), 32'd0);
    chk({tag, "_rd_en"},     32'(fifo_rd_en), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data), 32'd0);
    chk({tag, "_grant_id"},  32'(grant_id), 32'd0);
  endtask

  // mode 0 random, 1 only producer 0 (A), 2 both (3/C), 3 both with forced full, 4 idle stalled consumer, 5 idle ready consumer
  task automatic drive(input int mode);
    case (mode)
      1: begin req_valid = 2'b01; req_data = {4'($urandom), 4'hA}; force_full = 1'b0; out_ready = 1'b1; end
      2: begin req_valid = 2'b11; req_data = 8'hC3; force_full = 1'b0; out_ready = 1'b1; end
      3: begin req_valid = 2'b11; req_data = 8'hC3; force_full = 1'b1; out_ready = 1'b1; end
      4: begin req_valid = 2'b00; req_data = 8'($urandom); force_full = 1'b0; out_ready = 1'b0; end
      5: begin req_valid = 2'b00; req_data = 8'($urandom); force_full = 1'b0; out_ready = 1'b1; end
      default: begin
        req_valid  = 2'($urandom);
        req_data   = 8'($urandom);
        force_full = ($urandom_range(0, 4) == 0);
        out_ready  = 1'($urandom_range(0, 1));
      end
    endcase
    fifo_empty = (q.size() == 0);
    fifo_full  = (q.size() >= DEPTH) || force_full;
    if (rdata_next) begin
      fifo_rdata = 4'(pend_val);
      rdata_next = 1'b0;
    end else begin
      fifo_rdata = 4'($urandom);
    end
  endtask

  task automatic cycle(input int mode, input bit r);
    bit ws, rs, go, rd;
    int g, wd, exp_rdy;
    @(negedge clk);
    rst = r;
    drive(mode);
    #1;
    if (r) begin
      check_zero("rst");
      @(posedge clk);
      model_reset();
      return;
    end
    ws = ((t % WR_DIV) == WR_DIV - 1);
    rs = ((t % RD_DIV) == RD_DIV - 1);
    g  = -1;
    for (int k = 1; k <= N_REQ; k++) begin
      int i;
      i = (last_g + k) % N_REQ;
      if (g < 0 && ((req_valid >> i) & 1) != 0) g = i;
    end
    go = ws && !fifo_full && (g >= 0);
    wd = 0;
    exp_rdy = 0;
    if (go) begin
      wd      = int'(req_data[g*WIDTH +: WIDTH]);
      exp_rdy = 1 << g;
    end
    rd = !(pend > 0 || m_ov != 0) && rs && !fifo_empty;
    chk("wr_en",     32'(fifo_wr_en), 32'(go));
    chk("wdata",     32'(fifo_wdata), 32'(wd));
    chk("req_ready", 32'(req_ready),  32'(exp_rdy));
    chk("rd_en",     32'(fifo_rd_en), 32'(rd));
    chk("out_valid", 32'(out_valid),  32'(m_ov));
    if (m_ov != 0) chk("out_data", 32'(out_data), 32'(m_od));
    chk("grant_id",  32'(grant_id),   32'(m_gid));
    @(posedge clk);
    t++;
    if (go) begin
      last_g = g;
      m_gid  = g;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        m_ov = 1;
        m_od = pend_val;
      end
    end else if (rd) begin
      pend       = 1;
      pend_val   = q.pop_front();
      rdata_next = 1'b1;
    end else if (m_ov != 0 && out_ready) begin
      m_ov = 0;
    end
    if (go) q.push_back(wd);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_data   = 8'h00;
    fifo_full  = 1'b0;
    fifo_empty = 1'b0;
    fifo_rdata = '0;
    out_ready  = 1'b0;
    force_full = 1'b0;
    q          = '{5, 6, 7};
    model_reset();
    #1;
    check_zero("rst0");
    repeat (3) cycle(2, 1'b1);

    repeat (16) cycle(1, 1'b0);
    repeat (16) cycle(2, 1'b0);
    repeat (6)  cycle(3, 1'b0);
    repeat (8)  cycle(2, 1'b0);

    begin
      int n;
      n = 0;
      while (m_ov == 0 && n < 40) begin
        cycle(4, 1'b0);
        n++;
      end
      chk("hold_reached", 32'(m_ov), 32'd1);
    end
    repeat (10) cycle(4, 1'b0);
    cycle(5, 1'b0);
    repeat (8) cycle(4, 1'b0);

    // Asynchronous reset in the middle of a HOLD cycle.
    chk("hold_before_rst", 32'(m_ov), 32'd1);
    @(negedge clk);
    drive(4);
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    model_reset();
    cycle(4, 1'b1);
    repeat (20) cycle(5, 1'b0);

    repeat (600) cycle(0, 1'b0);
    cycle(0, 1'b1);
    repeat (200) cycle(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
